// File: rtl/ssc_seq_ctrl_if.sv
// ssc_seq_ctrl_if: order request and result bundle for the sequential snack calculator
interface ssc_seq_ctrl_if;
  logic        in_valid;
  logic [63:0] card_num;
  logic [8:0]  input_money;
  logic [31:0] snack_num;
  logic [31:0] price;
  logic        busy;
  logic        out_valid;
  logic        out_card_ok;
  logic [8:0]  out_change;
  modport master (
    output in_valid, card_num, input_money, snack_num, price,
    input  busy, out_valid, out_card_ok, out_change
  );
  modport slave (
    input  in_valid, card_num, input_money, snack_num, price,
    output busy, out_valid, out_card_ok, out_change
  );
endinterface

// File: rtl/ssc_seq_ctrl.sv
// ssc_seq_ctrl: one shared multiplier, serial Luhn check, insertion sort and greedy purchase loop
module ssc_seq_ctrl (
  input logic         clk,
  input logic         rst_n,
  ssc_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, BUY, DONE} state_t;
  state_t      state;
  logic [2:0]  cnt;
  logic [63:0] card;
  logic [31:0] qty;
  logic [31:0] unit;
  logic [7:0]  lst [8];
  logic [7:0]  nl [8];
  logic [7:0]  sum;
  logic [8:0]  rem;
  logic        stop;
  logic        busy;
  logic        out_valid;
  logic        out_card_ok;
  logic [8:0]  out_change;
  logic [7:0]  total;
  logic [7:0]  ge;
  logic [3:0]  lo;
  logic [3:0]  hi;
  logic [4:0]  dbl;
  logic        card_ok;
  assign bus.busy        = busy;
  assign bus.out_valid   = out_valid;
  assign bus.out_card_ok = out_card_ok;
  assign bus.out_change  = out_change;
  // shared multiplier, Luhn digit pair, and descending insertion of this slot's total (ties go after equals)
  always_comb begin
    total   = {4'd0, qty[{cnt, 2'b00} +: 4]} * {4'd0, unit[{cnt, 2'b00} +: 4]};
    lo      = card[{cnt, 3'b000} +: 4];
    hi      = card[{cnt, 3'b100} +: 4];
    dbl     = hi < 4'd5 ? {hi, 1'b0} : {hi, 1'b0} - 5'd9;
    card_ok = (sum % 8'd10) == 8'd0;
    for (int i = 0; i < 8; i++) ge[i] = (i < int'(cnt)) && (lst[i] >= total);
    nl[0] = ge[0] ? lst[0] : total;
    for (int i = 1; i < 8; i++) nl[i] = ge[i] ? lst[i] : ge[i-1] ? total : lst[i-1];
  end
  // order sequencer: capture, 8 load cycles, 8 buy cycles, one result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      card        <= 64'd0;
      qty         <= 32'd0;
      unit        <= 32'd0;
      sum         <= 8'd0;
      rem         <= 9'd0;
      stop        <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_card_ok <= 1'b0;
      out_change  <= 9'd0;
      for (int i = 0; i < 8; i++) lst[i] <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          out_valid   <= 1'b0;
          out_card_ok <= 1'b0;
          out_change  <= 9'd0;
          if (bus.in_valid && !busy) begin
            card  <= bus.card_num;
            qty   <= bus.snack_num;
            unit  <= bus.price;
            rem   <= bus.input_money;
            sum   <= 8'd0;
            stop  <= 1'b0;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= LOAD;
            for (int i = 0; i < 8; i++) lst[i] <= 8'd0;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          for (int i = 0; i < 8; i++) lst[i] <= nl[i];
          sum <= sum + {4'd0, lo} + {3'd0, dbl};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= BUY;
        end
        BUY: begin
          if (!stop && card_ok && {1'b0, lst[cnt]} <= rem) rem <= rem - {1'b0, lst[cnt]};
          else stop <= 1'b1;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          out_valid   <= 1'b1;
          out_card_ok <= card_ok;
          out_change  <= rem;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ssc_seq_ctrl.sv
// tb_ssc_seq_ctrl: directed and randomized orders checked against a sort-and-spend reference model
module tb_ssc_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  ssc_seq_ctrl_if bus ();
  ssc_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int luhn_sum(input logic [63:0] c);
    int s = 0;
    for (int p = 0; p < 16; p++) begin
      int d = int'(c[4*p +: 4]);
      if (p % 2 == 1) begin
        d = 2 * d;
        if (d > 9) d = d - 9;
      end
      s += d;
    end
    return s;
  endfunction
  function automatic int ref_change(input logic [63:0] c, input logic [31:0] q, input logic [31:0] pr, input int money);
    int t [8];
    int rem = money;
    for (int i = 0; i < 8; i++) t[i] = int'(q[4*i +: 4]) * int'(pr[4*i +: 4]);
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (t[j] > t[i]) begin
          int x = t[i];
          t[i] = t[j];
          t[j] = x;
        end
    if (luhn_sum(c) % 10 == 0)
      for (int i = 0; i < 8; i++) begin
        if (t[i] > rem) break;
        rem -= t[i];
      end
    return rem;
  endfunction
  task automatic run(input string tag, input logic [63:0] c, input logic [31:0] q, input logic [31:0] pr,
                     input logic [8:0] money, input bit hold, input bit exp_ok, input int exp_change);
    bit early = 1'b0;
    bus.card_num    = c;
    bus.snack_num   = q;
    bus.price       = pr;
    bus.input_money = money;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      bus.in_valid    = 1'b0;
      bus.card_num    = {$urandom, $urandom};
      bus.snack_num   = $urandom;
      bus.price       = $urandom;
      bus.input_money = 9'($urandom);
    end
    chk({tag, ".busy_after_capture"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) early = 1'b1;
    end
    chk({tag, ".no_early_valid"}, 32'(early), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".card_ok"}, 32'(bus.out_card_ok), 32'(exp_ok));
    chk({tag, ".change"}, 32'(bus.out_change), 32'(exp_change));
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".busy_drop"}, 32'(bus.busy), 32'd0);
    chk({tag, ".change_clear"}, 32'({bus.out_card_ok, bus.out_change}), 32'd0);
  endtask
  initial begin
    logic [63:0] card;
    logic [31:0] q, pr;
    logic [8:0]  money;
    bit          seen;
    int          s;
    bus.in_valid    = 1'b0;
    bus.card_num    = 64'd0;
    bus.snack_num   = 32'd0;
    bus.price       = 32'd0;
    bus.input_money = 9'd0;
    #3;
    chk("reset.outputs", 32'({bus.busy, bus.out_valid, bus.out_card_ok, bus.out_change}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run("valid_small", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h1234_5678, 9'd100, 1'b0, 1'b1, 64);
    run("greedy_stop", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h1234_5678, 9'd20, 1'b0, 1'b1, 5);
    run("bad_card", 64'h4111_1111_1111_1112, 32'h1111_1111, 32'h1234_5678, 9'd300, 1'b0, 1'b0, 300);
    run("max_vals", 64'h4111_1111_1111_1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'd511, 1'b0, 1'b1, 61);
    run("zero_qty", 64'h4111_1111_1111_1111, 32'h0000_0000, 32'hFFFF_FFFF, 9'd37, 1'b0, 1'b1, 37);
    run("hold_first", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h1234_5678, 9'd100, 1'b1, 1'b1, 64);
    run("hold_second", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h1234_5678, 9'd100, 1'b0, 1'b1, 64);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.out_valid) seen = 1'b1;
    end
    chk("hold.no_extra_capture", 32'(seen), 32'd0);
    run("back_to_back_a", 64'h4111_1111_1111_1111, 32'h2222_2222, 32'h1111_1111, 9'd15, 1'b0, 1'b1, 1);
    run("back_to_back_b", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h1234_5678, 9'd36, 1'b0, 1'b1, 0);
    bus.card_num    = 64'h4111_1111_1111_1111;
    bus.snack_num   = 32'h1111_1111;
    bus.price       = 32'h1234_5678;
    bus.input_money = 9'd100;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_buy.outputs", 32'({bus.busy, bus.out_valid, bus.out_card_ok, bus.out_change}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.out_valid) seen = 1'b1;
    end
    chk("reset_mid_buy.no_result", 32'(seen), 32'd0);
    run("after_reset", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h1234_5678, 9'd100, 1'b0, 1'b1, 64);
    for (int n = 0; n < 24; n++) begin
      for (int p = 0; p < 16; p++) card[4*p +: 4] = 4'($urandom_range(0, 9));
      if (n % 2 == 0) begin
        card[3:0] = 4'd0;
        s = luhn_sum(card);
        card[3:0] = 4'((10 - s % 10) % 10);
      end
      q     = (n % 3 == 0) ? ($urandom & 32'h3333_3333) : $urandom;
      pr    = $urandom;
      money = 9'($urandom_range(0, 511));
      run($sformatf("rand%0d", n), card, q, pr, money, 1'b0, luhn_sum(card) % 10 == 0,
          ref_change(card, q, pr, int'(money)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ssc_seq_ctrl.md
Name: ssc_seq_ctrl

Overview:
Sequential controller for the snack shopping calculator. It captures one order per handshake and time-shares a single 4x4 multiplier across the eight snack slots. It also validates the card with a serial Luhn accumulator, builds a descending-sorted list of item totals by insertion, and then runs a greedy purchase loop. It replaces the fully combinational calculator where area matters more than latency.

Parameters:
none (8 items, 16 BCD card digits and 9-bit money are fixed by the interface)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  order present this cycle; sampled only when busy=0
card_num  input  64  16 BCD digits; [63:60] most significant (leftmost)
input_money  input  9  money paid, unsigned
snack_num  input  32  8 x 4-bit quantities; slot i = [4i+3:4i]
price  input  32  8 x 4-bit unit prices; slot i = [4i+3:4i]
busy  output  1  high from the capture edge until out_valid drops
out_valid  output  1  one-cycle result strobe
out_card_ok  output  1  Luhn result, qualified by out_valid
out_change  output  9  change returned, qualified by out_valid

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 forces state IDLE and clears all registers. busy, out_valid, out_card_ok and out_change read 0. A reset mid-operation aborts the order; no result is produced.
- States: IDLE -> LOAD -> BUY -> DONE -> IDLE.
- IDLE: on a rising edge with in_valid=1, latch all inputs, clear the sorted list and Luhn sum, set busy=1, set item counter cnt=0, go to LOAD.
- in_valid while busy=1 is ignored; inputs need be valid only on the capture edge.
- LOAD (8 cycles, cnt 0..7):
  - Per cycle: total = snack_num slot cnt * price slot cnt, an 8-bit unsigned product (max 225) from the single shared multiplier.
  - Insert the total into an 8-entry list kept descending. Ties insert after the existing equal entries.
  - Luhn: add digit pair cnt to the sum. Digit at [8cnt+3:8cnt] is added as-is. Digit d at [8cnt+7:8cnt+4] is doubled: add 2d if d<5, else 2d-9. Sum is 8 bits (max 144).
  - After cnt=7, go to BUY with cnt=0.
- BUY (8 cycles, fixed length regardless of outcome):
  - Keep remaining money rem, initialised to input_money.
  - Per cycle, take list[cnt]. If the stop flag is clear and list[cnt] <= rem, then rem -= list[cnt]. Otherwise set the stop flag and make no further purchases.
  - The loop is greedy and in-order: once a more expensive item is unaffordable, later cheaper items are not bought.
  - If the Luhn sum mod 10 is not 0, no purchases occur and rem stays input_money.
  - A zero total is always bought, leaving rem unchanged.
- DONE: out_valid=1 for exactly one cycle, with out_card_ok = (sum mod 10 == 0) and out_change = rem.
- The cycle after DONE: out_valid=0, out_change=0, out_card_ok=0, busy=0, state IDLE. A new in_valid is accepted from that cycle on.
- Latency: capture at edge k puts out_valid high during cycle k+17..k+18 (8 LOAD + 8 BUY + 1). The result is identical for any input values.
- Arithmetic: all widths unsigned with no wrap. rem never underflows because subtraction happens only when list[cnt] <= rem.

Test Plan:
1. Valid card, small total: card 64'h4111_1111_1111_1111, snack_num 32'h1111_1111, price 32'h1234_5678, money 100 -> out_card_ok=1, out_change=64, out_valid at edge k+17 for one cycle.
2. Greedy stop: same order, money 20 -> buy 8 then 7, reject 6, stop -> out_change=5, even though 5 >= 5/4/... would fit.
3. Invalid card: card 64'h4111_1111_1111_1112, money 300 -> out_card_ok=0, out_change=300.
4. Maximum values: all snack_num and price nibbles 4'hF, money 511, valid card -> 511-225-225 = 61, out_change=61. Zero quantities (snack_num=0) with money 37 -> out_change=37.
5. Handshake: in_valid held high across a complete order -> exactly one capture per idle window and no capture while busy=1. A back-to-back order issued in the cycle after out_valid is accepted.
6. Reset mid-BUY: pull rst_n low at cycle k+12 -> all outputs 0 immediately, no out_valid. A new order after release completes normally with latency 17.
